// File: rtl/bcd_score_counter.sv
// bcd_score_counter: enable-driven BCD score adder with saturate/wrap overflow.
// Define SCORE_HISCORE_EN to build the high-score latch; otherwise hiscore/new_hi read 0.
module bcd_score_counter #(
   parameter int DIGITS   = 6,
   parameter bit SATURATE = 1'b1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  tick,
   input  logic [3:0]            step,
   input  logic                  state,
   input  logic                  clear,
   output logic [4*DIGITS-1:0]   score,
   output logic                  overflow,
   output logic [4*DIGITS-1:0]   hiscore,
   output logic                  new_hi
);
   logic [3:0]          step_c;
   logic [4*DIGITS-1:0] sum_n;
   logic [4:0]          s;
   logic                carry;
   assign step_c = (step > 4'd9) ? 4'd9 : step;
   // Single-cycle ripple: digit0 takes the step, every higher digit takes the carry.
   always_comb begin
      carry = 1'b0;
      sum_n = '0;
      s     = '0;
      for (int i = 0; i < DIGITS; i++) begin
         s     = {1'b0, score[4*i +: 4]} + ((i == 0) ? {1'b0, step_c} : {4'b0, carry});
         carry = s > 5'd9;
         sum_n[4*i +: 4] = carry ? s[3:0] - 4'd10 : s[3:0];
      end
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         score    <= '0;
         overflow <= 1'b0;
      end else if (clear) begin
         score    <= '0;
         overflow <= 1'b0;
      end else if (!state && tick) begin
         score <= (carry && SATURATE) ? {DIGITS{4'h9}} : sum_n;
         if (carry) overflow <= 1'b1;
      end
   end
`ifdef SCORE_HISCORE_EN
   logic state_q;
   // Valid BCD orders the same as plain binary, so a vector compare is MSD-first.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= 1'b0;
         hiscore <= '0;
         new_hi  <= 1'b0;
      end else begin
         state_q <= state;
         new_hi  <= 1'b0;
         if (state && !state_q && score > hiscore) begin
            hiscore <= score;
            new_hi  <= 1'b1;
         end
      end
   end
`else
   assign hiscore = '0;
   assign new_hi  = 1'b0;
`endif
endmodule

// File: doc/bcd_score_counter.md
# bcd_score_counter

Parametrised synchronous BCD score counter for the game datapath. It replaces the rippled per-digit score chain with a single-clock, enable-driven adder of configurable digit count and per-tick step, with saturate/wrap overflow handling. It can also keep a high score latched at each death. It sits between the game-state FSM (tick strobe, `state`) and the hex-display decoders, which consume the packed `score` and `hiscore` buses.

## Interface
- `DIGITS`, 6: number of BCD digits; legal range 1–8.
- `SATURATE`, 1: 1 = clamp at all-nines on overflow; 0 = wrap modulo 10^DIGITS.
- `clk` in 1: system clock; all state updates on its rising edge.
- `reset` in 1: asynchronous, active-high; clears every register.
- `tick` in 1: count strobe, one `clk` wide (e.g. 10 Hz enable from the game timer).
- `step` in 4: BCD amount added per tick; 0–9 legal; values 10–15 are clamped to 9.
- `state` in 1: 0 = alive (count), 1 = dead (freeze).
- `clear` in 1: synchronous clear of `score` and `overflow` (new game).
- `score` out 4*DIGITS: packed BCD; digit0 (ones) at [3:0], digit k at [4k+3:4k].
- `overflow` out 1: sticky; set on the first carry out of the top digit.
- `hiscore` out 4*DIGITS: best score, packed like `score` (macro-dependent).
- `new_hi` out 1: one-cycle pulse when `hiscore` is replaced (macro-dependent).

## Operation
- Reset values:
  - `score`, `hiscore`: 0.
  - `overflow`, `new_hi`: 0.
  - Internal `state_q`: 0.
- Priority each cycle: `reset` > `clear` > `state` == 1 (freeze) > `tick`.
- Increment when `tick` == 1, `state` == 0 and `clear` == 0:
  - Add step' = min(`step`, 9) to digit0.
  - Each digit computes sum = digit + carry_in. If sum > 9, digit <= sum − 10 and carry_out = 1.
  - The carry ripples combinationally through all DIGITS digits within one cycle.
  - Every digit stays in 0–9 at all times; no non-BCD code is ever stored.
- Carry out of the top digit:
  - Sets `overflow`.
  - SATURATE=1: `score` is forced to all nines and stays there.
  - SATURATE=0: `score` takes the wrapped value.
- `tick` with `step` = 0 leaves `score` unchanged and is not an error.
- `state` == 1 holds `score` and ignores `tick`. `clear` still acts while frozen.
- `clear` together with `tick` in the same cycle: `clear` wins and the tick is dropped.

## Timing
- `score` and `overflow` are registered: a tick sampled at edge n is visible after edge n. Latency is 1 cycle.
- Back-to-back ticks on consecutive cycles are each counted; no dead cycle.
- `state_q` registers `state` every cycle. A death is `state` == 1 while `state_q` == 0.
- High-score compare happens on the death cycle, against the registered `score`.
  - If `score` > `hiscore` (unsigned BCD compare, most significant digit first): `hiscore` <= `score` at that edge, and `new_hi` = 1 for exactly that following cycle.
  - Equal scores do not update `hiscore` or pulse `new_hi`.
- Death and `clear` in the same cycle: the compare uses the pre-clear `score`, and `score` clears at the same edge.
- `reset` asserted mid-count: all outputs go to 0 immediately. The first tick after deassertion yields `score` = step'.

## Configuration
- Macro `SCORE_HISCORE_EN` (defined):
  - `state_q`, the `hiscore` register, the comparator and `new_hi` are built as described.
- Macro `SCORE_HISCORE_EN` (undefined):
  - No high-score logic is built.
  - `hiscore` is tied to all zeros and `new_hi` is tied to 0.
  - Ports stay present so top-level wiring is unchanged.

## Test plan
- Count up: DIGITS=6, `step`=1, `state`=0, 10 single ticks -> `score` = 0x000010; after 1000 ticks -> 0x001000; `overflow`=0.
- Saturate: DIGITS=2, SATURATE=1, reach 0x95, `step`=7, 1 tick -> `score` = 0x99, `overflow`=1; a further tick leaves `score` = 0x99.
- Wrap: DIGITS=2, SATURATE=0, from 0x95, `step`=7, 1 tick -> `score` = 0x02, `overflow`=1; `clear` -> `score` 0x00, `overflow`=0.
- Freeze and priority:
  - `state`=1 with 5 ticks -> `score` unchanged.
  - `clear` and `tick` in the same cycle -> `score` 0.
  - `step`=12 -> adds 9.
- High score (`SCORE_HISCORE_EN`):
  - Score 0x000042, raise `state` -> `hiscore` 0x000042 and a one-cycle `new_hi`.
  - Next game dies at 0x000030 -> `hiscore` stays 0x000042 and there is no `new_hi`.
  - Without the macro -> `hiscore` stays 0 throughout.
- Async reset: assert `reset` between clock edges mid-count -> all outputs 0 without a clock edge; release, 1 tick with `step`=3 -> `score` 0x000003.
